// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative cache controller.
// Field helpers work on a widened address so one definition serves every parameter set.
package cache_pkg;

  localparam int MAX_ADDR_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
    return addr_w - $clog2(sets) - $clog2(line_bytes);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_tag(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int off_w, input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] addr_index(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int off_w, input int idx_w);
    return (addr >> off_w) & ((MAX_ADDR_W'(1) << idx_w) - MAX_ADDR_W'(1));
  endfunction

  // Word within the line; the two byte-offset bits are dropped.
  function automatic logic [MAX_ADDR_W-1:0] addr_word(input logic [MAX_ADDR_W-1:0] addr,
                                                      input int off_w);
    return (addr >> 2) & ((MAX_ADDR_W'(1) << (off_w - 2)) - MAX_ADDR_W'(1));
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim walk from the root and path update on access.
// Nodes are heap-ordered (children of n are 2n+1 and 2n+2); a 0 bit points to the lower half.
module plru_tree #(
  parameter int WAYS = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  tree_bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);

  always_comb begin
    int   node;
    logic b;
    victim = '0;
    node   = 0;
    b      = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) b = tree_bits[n];
      end
      victim[WAY_W-1-lvl] = b;
      node = 2 * node + 1 + int'(b);
    end
  end

  // Every node on the accessed path is flipped to point at the other subtree.
  always_comb begin
    int   node;
    logic a;
    next_bits = tree_bits;
    node      = 0;
    a         = 1'b0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      a = access_way[WAY_W-1-lvl];
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) next_bits[n] = ~a;
      end
      node = 2 * node + 1 + int'(a);
    end
  end

endmodule

// File: rtl/sa_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with tree PLRU.
// Sequences lookup, victim write-back and line refill between the core and a line-wide memory port.
module sa_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS          = 4,
  parameter int SETS          = 256,
  parameter int LINE_BYTES    = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  localparam int LINE_BITS    = LINE_BYTES * 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]    i_req_wdata,
  input  logic [3:0]               i_req_be,
  output logic                     o_rsp_valid,
  output logic [DATA_WIDTH-1:0]    o_rsp_data,
  output logic                     o_cache_hit,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  output logic                     o_mem_we,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  output logic [LINE_BITS-1:0]     o_mem_wdata,
  input  logic                     i_mem_rvalid,
  input  logic [LINE_BITS-1:0]     i_mem_rdata
);

  localparam int OFFSET_W = offset_w(LINE_BYTES);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDRESS_WIDTH, SETS, LINE_BYTES);
  localparam int WAY_W    = $clog2(WAYS);
  localparam int WORD_W   = OFFSET_W - 2;

  state_t state, next_state;

  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     req_we;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic [3:0]               req_be;
  logic [WAY_W-1:0]         victim_q;
  logic                     refill_acc;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_hit;

  logic [TAG_W-1:0]     tag_arr   [SETS][WAYS];
  logic [LINE_BITS-1:0] data_arr  [SETS][WAYS];
  logic [WAYS-1:0]      valid_arr [SETS];
  logic [WAYS-1:0]      dirty_arr [SETS];
  logic [WAYS-2:0]      plru_arr  [SETS];

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   idx;
  logic [WORD_W-1:0]    word_sel;
  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic                 any_inv;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     plru_victim;
  logic [WAY_W-1:0]     miss_victim;
  logic [WAY_W-1:0]     access_way;
  logic [WAYS-2:0]      plru_next;
  logic                 refill_done;
  logic [LINE_BITS-1:0] base_line;
  logic [LINE_BITS-1:0] merged_line;
  logic [DATA_WIDTH-1:0] load_word;

  assign req_tag  = TAG_W'(addr_tag(MAX_ADDR_W'(req_addr), OFFSET_W, INDEX_W));
  assign idx      = INDEX_W'(addr_index(MAX_ADDR_W'(req_addr), OFFSET_W, INDEX_W));
  assign word_sel = WORD_W'(addr_word(MAX_ADDR_W'(req_addr), OFFSET_W));

  // Tag compare plus lowest-invalid-way search over the indexed set.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_arr[idx][w] && (tag_arr[idx][w] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign hit         = |hit_vec;
  assign miss_victim = any_inv ? inv_way : plru_victim;
  assign access_way  = (state == LOOKUP) ? hit_way : victim_q;
  assign refill_done = (state == REFILL) && i_mem_rvalid && (refill_acc || i_mem_ready);

  plru_tree #(.WAYS(WAYS)) u_plru (
    .tree_bits  (plru_arr[idx]),
    .access_way (access_way),
    .victim     (plru_victim),
    .next_bits  (plru_next)
  );

  // A store hit merges into the cached line, a refill merges into the incoming line.
  always_comb begin
    base_line   = (state == LOOKUP) ? data_arr[idx][hit_way] : i_mem_rdata;
    merged_line = base_line;
    if (req_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) merged_line[{word_sel, 2'(k), 3'b000} +: 8] = req_wdata[8*k +: 8];
      end
    end
    load_word = base_line[{word_sel, 5'b00000} +: 32];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    o_mem_valid = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state)
      IDLE: if (i_req_valid) next_state = LOOKUP;
      LOOKUP: begin
        if (hit)                                                          next_state = RESPOND;
        else if (valid_arr[idx][miss_victim] && dirty_arr[idx][miss_victim]) next_state = WRITEBACK;
        else                                                              next_state = REFILL;
      end
      WRITEBACK: begin
        o_mem_valid = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {tag_arr[idx][victim_q], idx, {OFFSET_W{1'b0}}};
        o_mem_wdata = data_arr[idx][victim_q];
        if (i_mem_ready) next_state = REFILL;
      end
      REFILL: begin
        o_mem_valid = !refill_acc;
        if (!refill_acc) o_mem_addr = {req_tag, idx, {OFFSET_W{1'b0}}};
        if (refill_done) next_state = RESPOND;
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      o_mem_valid = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  assign o_req_ready = (state == IDLE) && !rst;
  assign o_rsp_valid = (state == RESPOND) && !rst;
  assign o_rsp_data  = o_rsp_valid ? rsp_data : '0;
  assign o_cache_hit = o_rsp_valid && rsp_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      req_be     <= '0;
      victim_q   <= '0;
      refill_acc <= 1'b0;
      rsp_data   <= '0;
      rsp_hit    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      if (state == IDLE && i_req_valid) begin
        req_addr  <= i_req_addr;
        req_we    <= i_req_we;
        req_wdata <= i_req_wdata;
        req_be    <= i_req_be;
      end
      if (state == LOOKUP) begin
        if (hit) begin
          rsp_data      <= req_we ? '0 : load_word;
          rsp_hit       <= 1'b1;
          plru_arr[idx] <= plru_next;
          if (req_we) dirty_arr[idx][hit_way] <= 1'b1;
        end else begin
          victim_q <= miss_victim;
        end
      end
      if (state == REFILL && i_mem_ready) refill_acc <= 1'b1;
      if (refill_done) begin
        refill_acc                <= 1'b0;
        rsp_data                  <= req_we ? '0 : load_word;
        rsp_hit                   <= 1'b0;
        valid_arr[idx][victim_q]  <= 1'b1;
        dirty_arr[idx][victim_q]  <= req_we;
        plru_arr[idx]             <= plru_next;
      end
    end
  end

  // Tag and data storage carry no reset; the cleared valid bits make them invisible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOOKUP && hit && req_we) data_arr[idx][hit_way] <= merged_line;
      if (refill_done) begin
        data_arr[idx][victim_q] <= merged_line;
        tag_arr[idx][victim_q]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_sa_cache_ctrl.sv
// Scoreboard bench for sa_cache_ctrl (4 ways, 4 sets, 16-byte lines) with a scripted memory model.
// Expected responses and memory requests are queued by the driver and checked by separate monitors.
module tb_sa_cache_ctrl;

  localparam int WAYS = 4;
  localparam int SETS = 4;
  localparam int LINE_BYTES = 16;
  localparam int LB = LINE_BYTES * 8;
  localparam logic [LB-1:0] REFILL_LINE = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [LB-1:0] DIRTY_LINE  = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBB3344, 32'hAAAAAAAA};

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, o_req_ready, i_req_we;
  logic [31:0]   i_req_addr, i_req_wdata;
  logic [3:0]    i_req_be;
  logic          o_rsp_valid, o_cache_hit;
  logic [31:0]   o_rsp_data;
  logic          o_mem_valid, i_mem_ready, o_mem_we;
  logic [31:0]   o_mem_addr;
  logic [LB-1:0] o_mem_wdata;
  logic          i_mem_rvalid;
  logic [LB-1:0] i_mem_rdata;

  typedef struct packed {logic [31:0] data; logic hit;} rsp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [LB-1:0] wdata;} mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];
  int   checks = 0;
  int   passes = 0;
  int   mem_delay = 0;
  bit   rvalid_same = 1'b1;

  sa_cache_ctrl #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES),
                  .DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_cache_hit(o_cache_hit),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [LB-1:0] wdata);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // Issues one request; when asked, returns edges from accept until o_rsp_valid is seen.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input bit wait_rsp, output int lat);
    int cyc;
    lat = -1;
    cyc = 0;
    @(negedge clk);
    while (!o_req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!o_req_ready) begin
      check_output("req_ready wait", 0, 1);
      return;
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_be = be;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    if (!wait_rsp) return;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        lat = cyc + 1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (lat < 0) check_output("rsp wait", 0, 1);
  endtask

  task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_data, input logic exp_hit, input int exp_lat);
    rsp_t r;
    int   lat;
    r.data = exp_data; r.hit = exp_hit;
    rsp_q.push_back(r);
    apply_stimulus(we, addr, wdata, be, 1'b1, lat);
    if (exp_lat > 0) check_output({name, " latency"}, 128'(lat), 128'(exp_lat));
  endtask

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (o_rsp_valid) begin
        if (rsp_q.size() == 0) check_output("unexpected rsp", 1, 0);
        else begin
          e = rsp_q.pop_front();
          check_output("rsp_data", o_rsp_data, e.data);
          check_output("cache_hit", o_cache_hit, e.hit);
        end
      end
    end
  end

  // Memory model: checks each new request once, then raises ready after mem_delay cycles.
  initial begin : mem_model
    mem_t e;
    bit   in_txn;
    bit   pend_rvalid;
    int   wait_cnt;
    in_txn = 1'b0; pend_rvalid = 1'b0; wait_cnt = 0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = REFILL_LINE;
    forever begin
      @(negedge clk);
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b0;
      if (rst) begin
        in_txn = 1'b0;
        pend_rvalid = 1'b0;
      end else if (o_mem_valid) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          wait_cnt = 0;
          if (mem_q.size() == 0) check_output("unexpected mem req", {o_mem_we, o_mem_addr}, 0);
          else begin
            e = mem_q.pop_front();
            check_output("mem_we", o_mem_we, e.we);
            check_output("mem_addr", o_mem_addr, e.addr);
            if (e.we) check_output("mem_wdata", o_mem_wdata, e.wdata);
          end
        end
        if (wait_cnt >= mem_delay) begin
          i_mem_ready = 1'b1;
          in_txn = 1'b0;
          if (!o_mem_we) begin
            if (rvalid_same) i_mem_rvalid = 1'b1;
            else pend_rvalid = 1'b1;
          end
        end else wait_cnt++;
      end else begin
        check_output("mem idle zero", {o_mem_we, o_mem_addr}, 0);
        if (pend_rvalid) begin
          i_mem_rvalid = 1'b1;
          pend_rvalid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int lat;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_req_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("ready in reset", o_req_ready, 0);
    check_output("rsp_valid in reset", o_rsp_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    check_output("ready after reset", o_req_ready, 1);

    push_mem(1'b0, 32'h100, '0);
    do_access("cold load", 1'b0, 32'h104, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 3);
    do_access("load hit", 1'b0, 32'h104, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    do_access("store hit", 1'b1, 32'h104, 32'h11223344, 4'b0011, 32'h0, 1'b1, 2);
    do_access("load merged", 1'b0, 32'h104, 0, 4'h0, 32'hBBBB3344, 1'b1, 2);

    mem_delay = 2; rvalid_same = 1'b0;
    push_mem(1'b0, 32'h040, '0);
    do_access("fill tag1", 1'b0, 32'h044, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 0);
    push_mem(1'b0, 32'h080, '0);
    do_access("fill tag2", 1'b0, 32'h084, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 0);
    push_mem(1'b0, 32'h0C0, '0);
    do_access("fill tag3", 1'b0, 32'h0C4, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 0);
    mem_delay = 0; rvalid_same = 1'b1;

    do_access("touch tag2", 1'b0, 32'h084, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    do_access("touch tag3", 1'b0, 32'h0C4, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    do_access("touch tag4", 1'b0, 32'h104, 0, 4'h0, 32'hBBBB3344, 1'b1, 2);
    // Tree bits now root=1, left=1, right=0: the walk lands on way 2 (tag 2), which is clean.
    push_mem(1'b0, 32'h140, '0);
    do_access("load tag5", 1'b0, 32'h144, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 3);
    do_access("tag1 kept", 1'b0, 32'h044, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    do_access("touch tag3 again", 1'b0, 32'h0C4, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    // Root=0 and left=0 now select way 0, the dirty tag-4 line.
    push_mem(1'b1, 32'h100, DIRTY_LINE);
    push_mem(1'b0, 32'h180, '0);
    do_access("dirty evict", 1'b0, 32'h184, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 4);
    push_mem(1'b0, 32'h080, '0);
    do_access("tag2 gone", 1'b0, 32'h084, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 3);

    push_mem(1'b0, 32'h010, '0);
    do_access("store be0 miss", 1'b1, 32'h014, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 3);
    do_access("load after be0", 1'b0, 32'h014, 0, 4'h0, 32'hBBBBBBBB, 1'b1, 2);
    mem_delay = 1; rvalid_same = 1'b0;
    push_mem(1'b0, 32'h020, '0);
    do_access("store miss merge", 1'b1, 32'h028, 32'h55667788, 4'b1111, 32'h0, 1'b0, 0);
    mem_delay = 0; rvalid_same = 1'b1;
    do_access("load store-miss", 1'b0, 32'h028, 0, 4'h0, 32'h55667788, 1'b1, 2);

    mem_delay = 30;
    push_mem(1'b0, 32'h100, '0);
    apply_stimulus(1'b0, 32'h104, 0, 4'h0, 1'b0, lat);
    for (int i = 0; i < 20 && !o_mem_valid; i++) @(negedge clk);
    check_output("refill pending", o_mem_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check_output("mem_valid in reset", o_mem_valid, 0);
    check_output("ready in mid reset", o_req_ready, 0);
    rst = 1'b0;
    mem_delay = 0;
    @(negedge clk);
    check_output("ready after mid reset", o_req_ready, 1);
    push_mem(1'b0, 32'h100, '0);
    do_access("load after reset", 1'b0, 32'h104, 0, 4'h0, 32'hBBBBBBBB, 1'b0, 3);

    repeat (5) @(negedge clk);
    check_output("rsp queue drained", 128'(rsp_q.size()), 0);
    check_output("mem queue drained", 128'(mem_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
